gcd_scheduler: RTL and testbench

- Shares one GCD engine (controller plus datapath pair, serial 16-bit operand bus) between N_REQ requesters.
- Arbitrates round-robin and sequences operand loading: A on the first load cycle, B on the second.
- Waits for engine done, returns the result to the granted requester, and guards against a hung engine with a timeout.
- Sits between client logic and the GCD engine; the engine itself is unchanged.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_scheduler_if.sv | 34 +++
 rtl/gcd_rr_arbiter.sv | 36 +++
 rtl/gcd_scheduler.sv | 153 +++++++++++++++
 tb/tb_gcd_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD scheduler slice.
//   - default widths/limits used as parameter defaults
//   - controller state encoding (3-bit, fixed values so checkers can decode it)
package gcd_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_BYPASS = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_scheduler_if.sv
// Bundle of client-side and engine-side signals of the GCD scheduler.
//   master : client logic + GCD engine (drives req/opa/opb, gcd_done/gcd_result)
//   slave  : the scheduler (drives responses, busy and the engine operand bus)
//
// Handshake: req[i] is a level raised by requester i and held, together with
// its opa/opb slices, until resp_valid[i] pulses for one cycle; that pulse
// carries resp_data/resp_err and completes the transaction. Dropping req[i]
// earlier does not cancel an operation already granted.
interface gcd_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] opa;
    logic [N_REQ*WIDTH-1:0] opb;
    logic [N_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic                   resp_err;
    logic                   busy;
    logic                   gcd_start;
    logic [WIDTH-1:0]       gcd_data;
    logic                   gcd_done;
    logic [WIDTH-1:0]       gcd_result;

    modport master (
        output req, opa, opb, gcd_done, gcd_result,
        input  resp_valid, resp_data, resp_err, busy, gcd_start, gcd_data
    );

    modport slave (
        input  req, opa, opb, gcd_done, gcd_result,
        output resp_valid, resp_data, resp_err, busy, gcd_start, gcd_data
    );
endinterface

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin search.
//   i_req       : request levels
//   i_rr_ptr    : index searched first
//   o_grant_idx : first set request at or after i_rr_ptr (with wrap)
//   o_any_req   : at least one request is set
module gcd_rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [IW-1:0]    o_grant_idx,
    output logic             o_any_req
);

    int w_idx;

    // Scan offsets from farthest to nearest so the nearest set request
    // is the last one written and therefore wins.
    always_comb begin
        o_grant_idx = '0;
        o_any_req   = 1'b0;
        w_idx       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (i_req[w_idx]) begin
                o_grant_idx = IW'(w_idx);
                o_any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one serial-operand GCD engine between N_REQ requesters.
//   i_clock : system clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : gcd_scheduler_if.slave (requests/responses and engine bus)
//   o_state : current controller state, for observation
// Flow: IDLE grants round-robin and latches operands; zero operands take the
// BYPASS shortcut, otherwise LOAD_A (start + A), LOAD_B (B), WAIT for done or
// timeout; RESP pulses resp_valid to the granted requester for one cycle.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int  WIDTH   = WIDTH_DEF,
    parameter int  N_REQ   = N_REQ_DEF,
    parameter int  TIMEOUT = TIMEOUT_DEF,
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    gcd_scheduler_if.slave  bus,
    output state_t          o_state
);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic [IW-1:0]    w_grant;
    logic             w_any_req;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic             w_cnt_last;

    gcd_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req       (bus.req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_idx (w_grant),
        .o_any_req   (w_any_req)
    );

    assign w_opa      = bus.opa[int'(w_grant)*WIDTH +: WIDTH];
    assign w_opb      = bus.opb[int'(w_grant)*WIDTH +: WIDTH];
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));
    assign o_state    = r_state;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = (w_opa == '0 || w_opb == '0) ? ST_BYPASS : ST_LOAD_A;
                end
            end
            ST_LOAD_A: w_next = ST_LOAD_B;
            ST_LOAD_B: w_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.gcd_done || w_cnt_last) begin
                    w_next = ST_RESP;
                end
            end
            ST_BYPASS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs are pure state decode of registered values, so reset clears
    // them (including gcd_start) without waiting for a clock edge.
    always_comb begin
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        bus.resp_err   = 1'b0;
        bus.busy       = (r_state != ST_IDLE);
        bus.gcd_start  = 1'b0;
        bus.gcd_data   = '0;
        case (r_state)
            ST_LOAD_A: begin
                bus.gcd_start = 1'b1;
                bus.gcd_data  = r_a;
            end
            ST_LOAD_B, ST_WAIT: bus.gcd_data = r_b;
            ST_RESP: begin
                bus.resp_valid[r_grant] = 1'b1;
                bus.resp_data           = r_result;
                bus.resp_err            = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant;
                        r_a     <= w_opa;
                        r_b     <= w_opb;
                    end
                end
                ST_LOAD_B: r_cnt <= '0;
                ST_WAIT: begin
                    // done wins over a timeout reached in the same cycle
                    if (bus.gcd_done) begin
                        r_result <= bus.gcd_result;
                        r_err    <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_BYPASS: begin
                    // one operand is zero, so A|B is the GCD
                    r_result <= r_a | r_b;
                    r_err    <= 1'b0;
                end
                ST_RESP: begin
                    if (int'(r_grant) == N_REQ - 1) begin
                        r_rr_ptr <= '0;
                    end else begin
                        r_rr_ptr <= r_grant + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
module tb_gcd_scheduler;
  import gcd_pkg::*;

  localparam int WIDTH   = 16;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;
  localparam int EW      = 3 + 1 + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();
  state_t dbg_state;

  gcd_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];

  logic [WIDTH-1:0] op_a[N_REQ];
  logic [WIDTH-1:0] op_b[N_REQ];
  int m_rr      = 0;
  int eng_mode  = 0;   // 0: answers after eng_delay WAIT cycles, 1: never answers
  int eng_delay = 10;
  int n_starts  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int a, b, t;
    a = int'(x);
    b = int'(y);
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return WIDTH'(a);
  endfunction

  function automatic int next_rr(input logic [N_REQ-1:0] p, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (p[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  // ---------------- GCD engine model ----------------
  initial begin
    int ep, ew;
    logic [WIDTH-1:0] ea, eb;
    ep = 0; ew = 0; ea = '0; eb = '0;
    bus.gcd_done   = 1'b0;
    bus.gcd_result = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ep = 0;
        bus.gcd_done   = 1'b0;
        bus.gcd_result = '0;
      end else if (bus.gcd_start) begin
        ea = bus.gcd_data;
        ep = 1;
        n_starts++;
        bus.gcd_done = 1'b0;
      end else begin
        case (ep)
          1: begin eb = bus.gcd_data; ew = 0; ep = 2; end
          2: begin
            ew++;
            if (eng_mode == 0 && ew == eng_delay) begin
              bus.gcd_done   = 1'b1;
              bus.gcd_result = ref_gcd(ea, eb);
              ep = 3;
            end else begin
              bus.gcd_result = WIDTH'($urandom);
            end
          end
          3: begin bus.gcd_done = 1'b0; bus.gcd_result = WIDTH'($urandom); ep = 0; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.resp_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_valid", 32'(bus.resp_valid), 32'(1) << e[EW-1:EW-3]);
            check("resp_data", 32'(bus.resp_data), 32'(e[WIDTH-1:0]));
            check("resp_err", 32'(bus.resp_err), 32'(e[WIDTH]));
          end
        end else begin
          check("idle_resp_zero", 32'({bus.resp_err, bus.resp_data}), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
  endtask

  // Raises mask together, predicts service order and results, waits for all.
  task automatic run_batch(input logic [N_REQ-1:0] mask, input bit scramble);
    logic [N_REQ-1:0] pend;
    int idx, exp_starts, exp_lat, first_lat, cyc, lat;
    logic err;
    logic [WIDTH-1:0] d;
    pend = mask;
    exp_starts = n_starts;
    exp_lat = -1;
    while (pend != '0) begin
      idx = next_rr(pend, m_rr);
      pend[idx] = 1'b0;
      m_rr = (idx + 1) % N_REQ;
      if (op_a[idx] == '0 || op_b[idx] == '0) begin
        d = ref_gcd(op_a[idx], op_b[idx]); err = 1'b0; lat = 2;
      end else begin
        exp_starts++;
        if (eng_mode == 1 || eng_delay > TIMEOUT) begin
          d = '0; err = 1'b1; lat = 3 + TIMEOUT;
        end else begin
          d = ref_gcd(op_a[idx], op_b[idx]); err = 1'b0; lat = 3 + eng_delay;
        end
      end
      if (exp_lat < 0) exp_lat = lat;
      exp_q.push_back({3'(idx), err, d});
    end
    for (int i = 0; i < N_REQ; i++) begin
      bus.opa[i*WIDTH +: WIDTH] = op_a[i];
      bus.opb[i*WIDTH +: WIDTH] = op_b[i];
    end
    bus.req = mask;
    first_lat = -1;
    cyc = 0;
    while (bus.req != '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 1) begin
        bus.opa = {N_REQ{WIDTH'($urandom)}};
        bus.opb = {N_REQ{WIDTH'($urandom)}};
      end
      if (bus.resp_valid != '0) begin
        if (first_lat < 0) first_lat = cyc;
        bus.req = bus.req & ~bus.resp_valid;
      end
    end
    check("batch_done", 32'(bus.req), 32'd0);
    bus.req = '0;
    @(negedge clk);
    check("first_latency", 32'(first_lat), 32'(exp_lat));
    check("gcd_start_count", 32'(n_starts), 32'(exp_starts));
    check("idle_after_batch", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N_REQ-1:0] m;
    int g;
    bus.req = '0;
    bus.opa = '0;
    bus.opb = '0;
    for (int i = 0; i < N_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_start", 32'(bus.gcd_start), 32'd0);
    check("rst_data", 32'(bus.gcd_data), 32'd0);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // single normal job
    op_a[0] = 16'd169; op_b[0] = 16'd39; eng_mode = 0; eng_delay = 10;
    run_batch(4'b0001, 1'b0);

    // round-robin ordering
    do_reset();
    op_a[0] = 16'd12; op_b[0] = 16'd18; op_a[2] = 16'd100; op_b[2] = 16'd75;
    eng_delay = 4;
    run_batch(4'b0101, 1'b0);
    op_a[1] = 16'd81; op_b[1] = 16'd27;
    run_batch(4'b0011, 1'b0);

    // zero-operand shortcut
    op_a[1] = 16'd25; op_b[1] = 16'd0;
    run_batch(4'b0010, 1'b0);
    op_a[1] = 16'd0; op_b[1] = 16'd0;
    run_batch(4'b0010, 1'b0);
    op_a[2] = 16'd0; op_b[2] = 16'd77;
    run_batch(4'b0100, 1'b0);

    // hung engine, then a normal job
    eng_mode = 1;
    op_a[0] = 16'd30; op_b[0] = 16'd45;
    run_batch(4'b0001, 1'b0);
    eng_mode = 0; eng_delay = 3;
    run_batch(4'b0001, 1'b0);

    // done coinciding with the last timeout cycle
    eng_delay = TIMEOUT;
    op_a[3] = 16'd1000; op_b[3] = 16'd35;
    run_batch(4'b1000, 1'b0);

    // reset in WAIT for requester 3
    eng_mode = 1;
    op_a[3] = 16'd99; op_b[3] = 16'd33;
    bus.opa[3*WIDTH +: WIDTH] = op_a[3];
    bus.opb[3*WIDTH +: WIDTH] = op_b[3];
    bus.req = 4'b1000;
    repeat (6) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_start", 32'(bus.gcd_start), 32'd0);
    check("midrst_data", 32'(bus.gcd_data), 32'd0);
    check("midrst_valid", 32'(bus.resp_valid), 32'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
    eng_mode = 0; eng_delay = 5;
    op_a[3] = 16'd48; op_b[3] = 16'd18;
    run_batch(4'b1000, 1'b0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) begin
        g = $urandom_range(1, 60);
        op_a[i] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'(g * $urandom_range(1, 500));
        op_b[i] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'(g * $urandom_range(1, 500));
      end
      eng_mode  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      eng_delay = $urandom_range(1, TIMEOUT + 3);
      run_batch(m, $countones(m) == 1);
    end

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
